// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// active-low segment table, blank pattern, scan states and digit count.
package disp_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low gfedcba patterns, indexed by hex digit value.
   localparam logic [6:0] SEG7 [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Operand/load handshake and display pin bundle for disp_scan_ctrl.
// The master side drives the operand; the slave side (the controller) drives the pins.
interface disp_scan_ctrl_if;
   import disp_pkg::*;

   logic [13:0]           num_in;
   logic                  load;
   logic                  mode;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;
   logic                  frame;

   modport master (output num_in, load, mode, input seg, an, frame);
   modport slave  (input num_in, load, mode, output seg, an, frame);

endinterface

// File: rtl/disp_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
   import disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG7[nibble_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with blanking gaps.
// Optional macro LZ_BLANK_EN enables leading-zero suppression on digits 3..1.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 16
)(
   input  logic             clk,
   input  logic             rst,
   disp_scan_ctrl_if.slave  bus
);

   localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

   scan_state_e           state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [13:0]           pend_q, pend_d;
   logic [15:0]           disp_q, disp_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_q, frame_d;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BLANK;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         pend_q  <= '0;
         disp_q  <= '0;
         seg_q   <= SEG_OFF;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   // Commit happens on the SHOW(3) -> BLANK(0) wrap, so a frame never tears;
   // a load on that same edge only reaches pend_q and waits a frame.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      disp_d  = disp_q;
      frame_d = 1'b0;
      pend_d  = pend_q;
      if (bus.load) begin
         pend_d = bus.mode ? (~bus.num_in + 14'd1) : bus.num_in;
      end
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               cnt_d   = '0;
               frame_d = (idx_q == 2'd0);
            end
         end
         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  disp_d = {2'b00, pend_q};
               end
            end
         end
         default: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   assign nibble = disp_d[{idx_d, 2'b00} +: 4];

   hex_to_seg7 u_dec (
      .nibble_i (nibble),
      .seg_o    (seg_dec)
   );

`ifdef LZ_BLANK_EN
   logic [15:0] upper;
   logic        lz_blank;
   assign upper    = disp_d >> {idx_d, 2'b00};
   assign lz_blank = (idx_d != 2'd0) && (upper == 16'd0);
`endif

   // Outputs are computed from next state so the pins change on the same edge as the FSM.
   always_comb begin
      seg_d = SEG_OFF;
      an_d  = '1;
      if (state_d == SHOW) begin
         an_d[idx_d] = 1'b0;
`ifdef LZ_BLANK_EN
         seg_d = lz_blank ? SEG_OFF : seg_dec;
`else
         seg_d = seg_dec;
`endif
      end
   end

   assign bus.seg   = seg_q;
   assign bus.an    = an_q;
   assign bus.frame = frame_q;

endmodule
